// File: rtl/regfile_seq_pkg.sv
// rtl/regfile_seq_pkg.sv - shared FSM encoding and requester ids for the register read sequencer
package regfile_seq_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_OPA = 2'd0;
  localparam logic [1:0] REQ_OPB = 2'd1;
  localparam logic [1:0] REQ_DBG = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    ACK   = 2'd3
  } state_t;

  // Round-robin successor over the three requesters.
  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == REQ_DBG) ? REQ_OPA : id + 2'd1;
  endfunction

endpackage

// File: rtl/regfile_read_sequencer_if.sv
// rtl/regfile_read_sequencer_if.sv - requester and multiplexer signals of the register read sequencer
interface regfile_read_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [2:0]         req;
  logic [4:0]         addr0;
  logic [4:0]         addr1;
  logic [4:0]         addr2;
  logic [2:0]         word;
  logic [4:0]         sel_o;
  logic [WIDTH-1:0]   mux_data;
  logic [2:0]         ack_o;
  logic [2*WIDTH-1:0] data_o;
  logic               busy_o;

  modport master (
    output req, addr0, addr1, addr2, word, mux_data,
    input  sel_o, ack_o, data_o, busy_o
  );

  modport slave (
    input  req, addr0, addr1, addr2, word, mux_data,
    output sel_o, ack_o, data_o, busy_o
  );
endinterface

// File: rtl/rr_arbiter_3.sv
// rtl/rr_arbiter_3.sv - combinational three-way round-robin pick starting after the last grant
module rr_arbiter_3
  import regfile_seq_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant_id,
  output logic       valid
);

  logic [1:0] cand;

  always_comb begin
    grant_id = REQ_OPA;
    valid    = 1'b0;
    cand     = next_id(last);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[cand]) begin
        grant_id = cand;
        valid    = 1'b1;
      end
      cand = next_id(cand);
    end
  end

endmodule

// File: rtl/regfile_read_sequencer.sv
// rtl/regfile_read_sequencer.sv - arbitrates three requesters and sequences byte/pair reads through a 32-way mux
module regfile_read_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_read_sequencer_if.slave  bus
);

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         last_grant;
  logic [1:0]         cur_id;
  logic [4:0]         cur_addr;
  logic               cur_word;
  logic [1:0]         grant_id;
  logic               grant_valid;
  logic [4:0]         win_addr;
  logic               win_word;
  logic [4:0]         sel_q;
  logic [2*WIDTH-1:0] data_q;

  rr_arbiter_3 u_arb (
    .req      (bus.req),
    .last     (last_grant),
    .grant_id (grant_id),
    .valid    (grant_valid)
  );

  always_comb begin
    win_addr = bus.addr2;
    case (grant_id)
      REQ_OPA: win_addr = bus.addr0;
      REQ_OPB: win_addr = bus.addr1;
      default: win_addr = bus.addr2;
    endcase
    win_word = bus.word[grant_id];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = RD_LO;
      RD_LO:   state_nxt = cur_word ? RD_HI : ACK;
      RD_HI:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The select is registered one state early so mux_data is settled for the whole capture cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= REQ_DBG;
      cur_id     <= REQ_OPA;
      cur_addr   <= '0;
      cur_word   <= 1'b0;
      sel_q      <= '0;
      data_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cur_id     <= grant_id;
            cur_addr   <= win_addr;
            cur_word   <= win_word;
            last_grant <= grant_id;
            sel_q      <= win_word ? {win_addr[4:1], 1'b0} : win_addr;
          end
        end
        RD_LO: begin
          data_q <= {{WIDTH{1'b0}}, bus.mux_data};
          if (cur_word) sel_q <= {cur_addr[4:1], 1'b1};
        end
        RD_HI: data_q[2*WIDTH-1:WIDTH] <= bus.mux_data;
        default: ;
      endcase
    end
  end

  assign bus.sel_o  = sel_q;
  assign bus.data_o = data_q;
  assign bus.busy_o = (state != IDLE);
  assign bus.ack_o  = (state == ACK) ? (3'b001 << cur_id) : 3'b000;

endmodule

// File: doc/regfile_read_sequencer.md
REGFILE_READ_SEQUENCER -- requirements
Module: regfile_read_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the register byte width, equal to the WIDTH of the 32-way register-file multiplexer being driven.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  3  per-requester request (bit0 operand A, bit1 operand B, bit2 debug).
REQ-005 addr0, addr1, addr2  input  5 each  register index per requester.
REQ-006 word  input  3  per-requester pair read (1 = 16-bit Rn+1:Rn, 0 = single byte).
REQ-007 sel_o  output  5  select driven to the 32-way multiplexer S input.
REQ-008 mux_data  input  WIDTH  multiplexer out, combinational from sel_o.
REQ-009 ack_o  output  3  one-hot, one-cycle completion pulse per requester.
REQ-010 data_o  output  2*WIDTH  read result, valid only while any ack_o bit is high; upper byte is zero for byte reads.
REQ-011 busy_o  output  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, RD_LO, RD_HI and ACK.
REQ-013 In IDLE with req != 0, the block SHALL grant one requester round-robin, starting from (last_grant+1) mod 3 and skipping idle bits.
REQ-014 On a grant, the block SHALL latch the winner's id, addr and word bit, update last_grant, and enter RD_LO.
REQ-015 In IDLE with req == 0, the block SHALL stay in IDLE and leave last_grant unchanged.
REQ-016 In RD_LO, sel_o SHALL equal {addr[4:1], 0} when word=1, else addr.
REQ-017 In RD_LO, mux_data SHALL be captured into data_o[WIDTH-1:0]; next state is RD_HI if word=1, else ACK.
REQ-018 In RD_HI, sel_o SHALL equal {addr[4:1], 1} and mux_data SHALL be captured into data_o[2*WIDTH-1:WIDTH]; next state is ACK.
REQ-019 For word reads addr[0] SHALL be ignored, so pairs are always even-aligned and never wrap past R31 (addr 31 word gives R31:R30).
REQ-020 In ACK, ack_o SHALL assert the latched requester's bit for exactly one cycle; next state is IDLE.
REQ-021 Latency from req sampled in IDLE to ack SHALL be 2 cycles for a byte read and 3 cycles for a word read; peak throughput is one transaction per 3 cycles (byte).
REQ-022 Changes to req, addr or word after the grant cycle SHALL NOT affect the transaction in progress.
REQ-023 A req bit still high during ACK SHALL be ignored in that cycle and re-arbitrated in the following IDLE cycle.
REQ-024 Simultaneous requests SHALL be served one at a time; no requester SHALL wait more than 2 other transactions.
REQ-025 In IDLE and ACK, sel_o SHALL hold its last driven value.
REQ-026 data_o SHALL hold its value between captures.

Reset
REQ-027 Reset SHALL force the following values: state IDLE, sel_o 0, ack_o 0, data_o 0, busy_o 0, and last_grant 2 (so requester 0 wins first).
REQ-028 Reset asserted mid-transaction SHALL abort it with no ack_o pulse; after release the aborted request SHALL be re-arbitrated as a new request if still held.

Structure
REQ-029 A shared package regfile_seq_pkg SHALL hold the FSM state encoding, the requester id constants (REQ_OPA=0, REQ_OPB=1, REQ_DBG=2) and the requester count 3.
REQ-030 The round-robin selection SHALL be a single sub-module rr_arbiter_3 with inputs req[2:0] and last[1:0], outputs grant_id[1:0] and valid, purely combinational.
REQ-031 The multiplexer SHALL be instantiated outside this block; this block SHALL own only sel_o.

Verification
REQ-032 Byte read: req=001, addr0=5, word=000, and R5=0x3C -> sel_o=5 in RD_LO; ack_o=001 two cycles after the request is sampled, data_o=0x003C.
REQ-033 Word read: req=010, addr1=27, word=010, R26=0x11, R27=0x22 -> sel_o=26 then 27; ack_o=010 at +3 cycles, data_o=0x2211.
REQ-034 Contention: req=111 held, all byte reads -> ack order is 0, 1, 2, 0 with acks spaced 3 cycles apart.
REQ-035 Top boundary: word read with addr2=31, R30=0xAA, R31=0x55 -> sel_o=30 then 31, data_o=0x55AA, ack_o=100.
REQ-036 Reset mid-word: reset pulsed in RD_HI -> no ack_o, all outputs 0; with req held after release, the transaction restarts and acks 3 cycles later.
REQ-037 Stability: addr0 changed from 4 to 9 during RD_LO of a byte read -> the result still reflects R4.
